// File: rtl/radix16_mult_ctrl_pkg.sv
// Shared definitions for the radix-16 Booth multiplier controller:
// controller state encoding, operand/product widths and step geometry.
package radix16_mult_ctrl_pkg;

  localparam int OP_W       = 32;
  localparam int PROD_W     = 2 * OP_W;
  localparam int STEPS      = 8;
  localparam int DIGIT_BITS = 4;
  localparam int BX_W       = OP_W + 1;
  localparam int CNT_W      = $clog2(STEPS);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage

// File: rtl/radix16_mult_ctrl_digit_decode.sv
// Radix-16 Booth digit decoder: maps a 5-bit overlapping window of the
// multiplier onto a signed digit in -8..+8, returned as sign + magnitude.
module radix16_digit_decode
  import radix16_mult_ctrl_pkg::*;
(
  input  logic [DIGIT_BITS:0]   win,
  output logic                  sign,
  output logic [DIGIT_BITS-1:0] mag
);

  logic [DIGIT_BITS:0] digit_val;

  // d = -8*w4 + 4*w3 + 2*w2 + w1 + w0: the top four bits read as a signed
  // nibble plus the overlap bit; one extra bit holds the +8 case.
  always_comb begin
    digit_val = {win[DIGIT_BITS], win[DIGIT_BITS:1]} + {{DIGIT_BITS{1'b0}}, win[0]};
    sign      = digit_val[DIGIT_BITS];
    mag       = sign ? ((~digit_val[DIGIT_BITS-1:0]) + DIGIT_BITS'(1))
                     : digit_val[DIGIT_BITS-1:0];
  end

endmodule

// File: rtl/radix16_mult_ctrl.sv
// Sequential 32x32 signed multiplier, one radix-16 Booth digit per cycle.
// Optional build macro MULT_EARLY_EXIT_EN: finish as soon as the remaining
// multiplier bits are pure sign extension (their digits are all zero).
module radix16_mult_ctrl
  import radix16_mult_ctrl_pkg::*;
(
  input  logic              Clk,
  input  logic              Rst_n,
  input  logic              Start,
  input  logic [OP_W-1:0]   A,
  input  logic [OP_W-1:0]   B,
  output logic              Busy,
  output logic              Done,
  output logic [PROD_W-1:0] Result,
  output logic [CNT_W-1:0]  Count
);

  state_t              state_reg, state_next;
  logic [OP_W-1:0]     a_reg, a_next;
  logic [BX_W-1:0]     bx_reg, bx_next;
  logic [PROD_W-1:0]   acc_reg, acc_next;
  logic [PROD_W-1:0]   result_reg, result_next;
  logic [CNT_W-1:0]    count_reg, count_next;

  logic [DIGIT_BITS:0]   win_arr [STEPS];
  logic [DIGIT_BITS:0]   cur_win;
  logic                  dig_sign;
  logic [DIGIT_BITS-1:0] dig_mag;
  logic [PROD_W-1:0]     a_ext, mag_ext, prod, term, term_shifted;
  logic [4:0]            step_shamt;
  logic                  last_step;

  // Overlapping 5-bit windows of {B, 0}, one per step.
  generate
    for (genvar gi = 0; gi < STEPS; gi++) begin : g_win
      assign win_arr[gi] = bx_reg[gi*DIGIT_BITS +: DIGIT_BITS+1];
    end
  endgenerate

  assign cur_win = win_arr[count_reg];

  radix16_digit_decode u_decode (
    .win  (cur_win),
    .sign (dig_sign),
    .mag  (dig_mag)
  );

  // Partial product for the current digit, weighted by 16^step.
  always_comb begin
    a_ext        = {{OP_W{a_reg[OP_W-1]}}, a_reg};
    mag_ext      = {{(PROD_W-DIGIT_BITS){1'b0}}, dig_mag};
    prod         = a_ext * mag_ext;
    term         = dig_sign ? (PROD_W'(0) - prod) : prod;
    step_shamt   = {count_reg, 2'b00};
    term_shifted = term << step_shamt;
  end

`ifdef MULT_EARLY_EXIT_EN
  logic [BX_W-1:0] bx_upper;
  logic [5:0]      upper_shamt;

  // Bits above the current window are all sign copies once the arithmetic
  // shift leaves only zeros or only ones; every later digit is then zero.
  assign upper_shamt = {1'b0, count_reg, 2'b00} + 6'd4;
  assign bx_upper    = $signed(bx_reg) >>> upper_shamt;
  assign last_step   = (bx_upper == '0) || (bx_upper == '1);
`else
  assign last_step   = (count_reg == CNT_W'(STEPS-1));
`endif

  // Next-state and datapath update: accept in IDLE/DONE, accumulate in RUN.
  always_comb begin
    state_next  = state_reg;
    a_next      = a_reg;
    bx_next     = bx_reg;
    acc_next    = acc_reg;
    result_next = result_reg;
    count_next  = count_reg;
    case (state_reg)
      IDLE, DONE: begin
        if (Start) begin
          a_next     = A;
          bx_next    = {B, 1'b0};
          acc_next   = '0;
          count_next = '0;
          state_next = RUN;
        end else if (state_reg == DONE) begin
          state_next = IDLE;
        end
      end
      RUN: begin
        acc_next = acc_reg + term_shifted;
        if (last_step) begin
          result_next = acc_reg + term_shifted;
          count_next  = '0;
          state_next  = DONE;
        end else begin
          count_next  = count_reg + CNT_W'(1);
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // Controller state register.
  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) state_reg <= IDLE;
    else        state_reg <= state_next;
  end

  // Operand, accumulator, result and step-count registers.
  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      a_reg      <= '0;
      bx_reg     <= '0;
      acc_reg    <= '0;
      result_reg <= '0;
      count_reg  <= '0;
    end else begin
      a_reg      <= a_next;
      bx_reg     <= bx_next;
      acc_reg    <= acc_next;
      result_reg <= result_next;
      count_reg  <= count_next;
    end
  end

  assign Busy   = (state_reg == RUN);
  assign Done   = (state_reg == DONE);
  assign Result = result_reg;
  assign Count  = count_reg;

endmodule

// File: doc/radix16_mult_ctrl.md
RADIX16_MULT_CTRL -- requirements
Module: radix16_mult_ctrl

Interface
REQ-001 SHALL have no parameters; operand width fixed at 32 bits, product width 64 bits, 8 radix-16 steps.
REQ-002 SHALL have port Clk  input  1  single clock, all state updates on rising edge.
REQ-003 SHALL have port Rst_n  input  1  reset, asynchronous assert, active-low.
REQ-004 SHALL have port Start  input  1  request; sampled only when not Busy.
REQ-005 SHALL have port A  input  32  signed multiplicand, captured on Start accept.
REQ-006 SHALL have port B  input  32  signed multiplier, captured on Start accept.
REQ-007 SHALL have port Busy  output  1  high while the multiply is in progress.
REQ-008 SHALL have port Done  output  1  one-cycle pulse when Result becomes valid.
REQ-009 SHALL have port Result  output  64  signed product, held until the next Start accept.
REQ-010 SHALL have port Count  output  3  current step index, 0..7.

Function
REQ-011 SHALL implement states IDLE, RUN and DONE.
REQ-012 SHALL accept Start in IDLE or DONE: capture A, capture Bx = {B, 1'b0} (33 bits), clear accumulator, set Count=0, enter RUN.
REQ-013 SHALL, in RUN step i, use window W = Bx[4i+4:4i] (5 bits; overlapping windows).
REQ-014 SHALL decode the digit as -16*W[4] + 8*W[3] + 4*W[2] + 2*W[1] + W[0] - W[0]... specifically d = -8*W[4] + 4*W[3] + 2*W[2] + W[1] + W[0], giving d in -8..+8, output as Sign plus 4-bit magnitude 0..8.
REQ-015 SHALL, per step, add (Sign ? -(mag*A) : mag*A) to the accumulator; the term is sign-extended to 64 bits and shifted left by 4*i.
REQ-016 SHALL increment Count each RUN cycle; after the step with Count=7 it SHALL enter DONE, load Result and assert Done.
REQ-017 SHALL produce Done exactly 8 cycles after the Start-accept edge (non-early-exit build).
REQ-018 SHALL drive Busy high in RUN only; Start SHALL be ignored while Busy is high.
REQ-019 SHALL return from DONE to IDLE after one cycle unless Start is high, in which case it SHALL accept Start (back-to-back operation).
REQ-020 SHALL produce the exact two's-complement product for all operands, including A = B = 0x80000000, which gives 0x4000000000000000.
REQ-021 SHALL leave Result unchanged during RUN; Result updates only at entry to DONE.

Reset
REQ-022 SHALL, on Rst_n low (at any time, including mid-RUN), immediately force IDLE, Busy=0, Done=0, Count=0, Result=0 and accumulator=0, and SHALL discard any in-flight operation.
REQ-023 SHALL ignore Start in the first cycle after Rst_n deasserts only if it is sampled before that edge; no other special handling applies.

Configuration
REQ-024 SHALL support the macro MULT_EARLY_EXIT_EN. When it is defined, at step i the block SHALL go to DONE after the current step if Bx[32:4i+4] is all-zeros or all-ones, so Done arrives in i+1 cycles. When it is undefined, the block SHALL always run 8 steps.
REQ-025 SHALL produce identical Result values whether or not MULT_EARLY_EXIT_EN is defined.

Structure
REQ-026 SHALL place the state enum (IDLE/RUN/DONE), STEPS=8, DIGIT_BITS=4 and OP_W=32 in the shared multiplier package.
REQ-027 SHALL implement the digit decode (window to Sign/magnitude) as a sub-module, radix16_digit_decode, which the controller instantiates.

Verification
REQ-028 Scenario: A=3, B=5, Start pulse -> Busy for 8 cycles, Done on the 8th edge, Result=15, Count observed stepping 0..7.
REQ-029 Scenario: A=-7, B=0x7FFFFFFF -> Result=0xFFFFFFFC80000007; A=B=0x80000000 -> Result=0x4000000000000000.
REQ-030 Scenario: Start held high through DONE -> a second operation begins without passing through IDLE, and Done pulses exactly once per operation.
REQ-031 Scenario: Rst_n pulsed low at Count=4 -> all outputs read 0 immediately; a Start afterwards with A=2, B=2 -> Result=4.
REQ-032 Scenario: Start asserted while Busy with different operands -> ignored, and the first operation's Result is unaffected.
REQ-033 Scenario: with MULT_EARLY_EXIT_EN defined, A=9, B=1 -> Done 1 cycle after accept, Result=9; B=-1 -> Done 1 cycle after accept, Result=-9; 1000 random operand pairs SHALL match the reference product in both builds.
